mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, word-addressed synchronous RAM between the instruction-fetch port (I, read-only) and the
//  load/store port (D), which carries pre-shifted data and byte select. Sits between IF/MEM stages and the RAM macro.
//  One access in flight at a time; pipeline stalls while its ack is outstanding. D has priority, bounded by starvation guard.
// PARAMETERS
//  ADDR_BITS   32  word-address width on both ports and RAM
//  DATA_BITS   32  data width
//  RAM_LAT     1   RAM read latency in cycles from ram_en to valid ram_dout (>=1)
//  STARVE_MAX  4   consecutive D grants tolerated while i_req pending before I is forced
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous reset, active low
//  i_req      in   1          fetch request, held until i_ack
//  i_addr     in   ADDR_BITS  fetch word address
//  i_ack      out  1          one-cycle pulse: fetch complete, i_rdata valid same cycle
//  i_rdata    out  DATA_BITS  fetched word (registered, holds until next I read)
//  d_req      in   1          load/store request, held until d_ack
//  d_we       in   1          1 = store, 0 = load
//  d_addr     in   ADDR_BITS  word address
//  d_wdata    in   DATA_BITS  store data, already lane-aligned
//  d_sel      in   4          store byte enables; ignored for loads
//  d_ack      out  1          one-cycle pulse: access complete; d_rdata valid for loads
//  d_rdata    out  DATA_BITS  loaded word (registered)
//  ram_en     out  1          RAM access strobe, one cycle per access
//  ram_we     out  1          RAM write enable (qualified by ram_en)
//  ram_addr   out  ADDR_BITS  RAM word address
//  ram_din    out  DATA_BITS  RAM write data
//  ram_sel    out  4          RAM byte enables
//  ram_dout   in   DATA_BITS  RAM read data
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, starve_cnt=0; every output 0 incl. i_rdata/d_rdata; in-flight access dropped, no ack.
//  All ram_* outputs, acks and rdata are registered. FSM states:
//   IDLE  : no req -> IDLE. Grant D if d_req && !(i_req && starve_cnt==STARVE_MAX), else I if i_req -> ISSUE.
//           Grant latches owner, addr, we, wdata, sel (sel forced 4'hf for reads); later port changes ignored.
//   ISSUE : ram_en=1 for exactly one cycle with latched fields. Write -> DONE. Read -> WAIT.
//   WAIT  : counts RAM_LAT cycles from ISSUE; in last count cycle sample ram_dout into owner's rdata -> DONE.
//   DONE  : pulse owner's ack for one cycle -> IDLE. Requester drops/changes req in ack cycle.
//  Latency (req seen in IDLE at cycle 0): write ack at cycle 2; read ack at cycle 2+RAM_LAT. Min spacing between accesses 3.
//  Starvation: starve_cnt increments (saturates at STARVE_MAX) on each D grant while i_req=1; clears on I grant or i_req=0 in IDLE.
//  Simultaneous i_req & d_req with starve_cnt<STARVE_MAX: D wins. Same at STARVE_MAX: I wins, cnt clears.
//  Req withdrawn after grant: access still completes and ack still pulses (no abort). Requests never queued beyond the held req.
//  d_we=1 with d_sel=0: issued with ram_we=1, ram_sel=0 (RAM no-op), acked normally.
//  ram_addr passes word address unchanged (no shift); no address checking. At most one ack asserted per cycle.
// STRUCTURE
//  Shared header mem_arb_defs.vh: state encodings (IDLE/ISSUE/WAIT/DONE, 2 bits), OWNER_I/OWNER_D, SEL_ALL=4'hf.
//  Sub-module mem_arb_starve_ctr: saturating counter, inputs inc/clr, output at_max; width $clog2(STARVE_MAX+1).
//  Top holds FSM, request latch, RAM_LAT wait counter, rdata/ack registers.
// TESTING (RAM model honours RAM_LAT; check every cycle against reference model)
//  Reset: assert rst_n=0 mid-read in WAIT -> all outputs 0 immediately, no ack after release, busy=0.
//  Lone I read addr 0x10, RAM word 0xDEADBEEF, RAM_LAT=1 -> ram_en,ram_we=0,ram_sel=f at cycle 1; i_ack+i_rdata=DEADBEEF at cycle 3.
//  D store addr 0x4, wdata 0x00AB0000, sel 4'b0100 -> ram_we=1,ram_sel=4'b0100 at cycle 1; d_ack at cycle 2; no i_ack.
//  Both req together, STARVE_MAX=4, d_req held continuously -> D granted 4 times, then I on 5th arbitration, cnt back to 0.
//  Req dropped right after grant -> ack still pulses once; ram_addr stays latched value even if d_addr changes during WAIT.
//  RAM_LAT=3 read -> ack exactly at cycle 5; d_rdata holds value until next D load completes.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
// The FSM encoding, owner tags and full-word byte mask live here.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic       OWNER_I = 1'b0;
    localparam logic       OWNER_D = 1'b1;
    localparam logic [3:0] SEL_ALL = 4'hf;

    // Loads always fetch the full word; only stores honour the byte enables.
    function automatic logic [3:0] issue_sel(input logic we, input logic [3:0] sel);
        logic [3:0] res;
        if (we) begin
            res = sel;
        end else begin
            res = SEL_ALL;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of D grants taken while a fetch was waiting.
// at_max tells the arbiter to hand the next slot to the fetch port.
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, increment stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(STARVE_MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port (I) and the
// load/store port (D); one access in flight, D preferred unless I is starving.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 32,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic                 i_ack,
    output logic [DATA_BITS-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [DATA_BITS-1:0] d_wdata,
    input  logic [3:0]           d_sel,
    output logic                 d_ack,
    output logic [DATA_BITS-1:0] d_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_din,
    output logic [3:0]           ram_sel,
    input  logic [DATA_BITS-1:0] ram_dout,
    output logic                 busy
);

    localparam int WAIT_W = $clog2(RAM_LAT + 1);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 ram_en_q, ram_en_d;
    logic                 ram_we_q, ram_we_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_BITS-1:0] ram_din_q, ram_din_d;
    logic [3:0]           ram_sel_q, ram_sel_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic [DATA_BITS-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_BITS-1:0] d_rdata_q, d_rdata_d;
    logic                 busy_q, busy_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic grant_d_s;
    logic grant_i_s;
    logic starve_inc_s;
    logic starve_clr_s;
    logic starve_at_max_s;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (starve_inc_s),
        .clr    (starve_clr_s),
        .at_max (starve_at_max_s)
    );

    assign grant_d_s = d_req && !(i_req && starve_at_max_s);
    assign grant_i_s = i_req && !grant_d_s;

    // FSM next state, request latch and registered-output next values.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ram_en_d     = 1'b0;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_sel_d    = ram_sel_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        wait_cnt_d   = wait_cnt_q;
        starve_inc_s = 1'b0;
        starve_clr_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                starve_clr_s = !i_req || grant_i_s;
                starve_inc_s = grant_d_s && i_req;
                if (grant_d_s) begin
                    owner_d    = OWNER_D;
                    ram_en_d   = 1'b1;
                    ram_we_d   = d_we;
                    ram_addr_d = d_addr;
                    ram_din_d  = d_wdata;
                    ram_sel_d  = issue_sel(d_we, d_sel);
                    state_d    = ST_ISSUE;
                end else if (grant_i_s) begin
                    owner_d    = OWNER_I;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = i_addr;
                    ram_din_d  = '0;
                    ram_sel_d  = SEL_ALL;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ram_we_q) begin
                    i_ack_d = (owner_q == OWNER_I);
                    d_ack_d = (owner_q == OWNER_D);
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = WAIT_W'(1);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The ack and rdata go out together in DONE, so sample on the last wait cycle.
                if (wait_cnt_q == WAIT_W'(RAM_LAT)) begin
                    if (owner_q == OWNER_D) begin
                        d_rdata_d = ram_dout;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = ram_dout;
                        i_ack_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_I;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_sel_q  <= 4'h0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_sel_q  <= ram_sel_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign i_ack    = i_ack_q;
    assign i_rdata  = i_rdata_q;
    assign d_ack    = d_ack_q;
    assign d_rdata  = d_rdata_q;
    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_sel  = ram_sel_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-timeline reference model checked every
// cycle on a RAM_LAT=1 instance, plus literal checks on a RAM_LAT=3 instance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int LAT3 = 3;
    localparam int SMAX = 4;
    localparam int MW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, i_req, i_ack, d_req, d_we, d_ack, ram_en, ram_we, busy;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, ram_addr, ram_din, ram_dout;
    logic [3:0]  d_sel, ram_sel;

    logic        rst_n3, i_req3, i_ack3, d_req3, d_we3, d_ack3, ram_en3, ram_we3, busy3;
    logic [31:0] i_addr3, i_rdata3, d_addr3, d_wdata3, d_rdata3, ram_addr3, ram_din3, ram_dout3;
    logic [3:0]  d_sel3, ram_sel3;

    mem_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .RAM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_ack(d_ack), .d_rdata(d_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_sel(ram_sel), .ram_dout(ram_dout), .busy(busy));

    mem_port_arbiter #(.ADDR_BITS(32), .DATA_BITS(32), .RAM_LAT(LAT3), .STARVE_MAX(SMAX)) dut3 (
        .clk(clk), .rst_n(rst_n3), .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_sel(d_sel3),
        .d_ack(d_ack3), .d_rdata(d_rdata3), .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
        .ram_din(ram_din3), .ram_sel(ram_sel3), .ram_dout(ram_dout3), .busy(busy3));

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] f3(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // ---------------- reference model (main instance) ----------------
    // Each access is a record: the IDLE cycle g it was granted in, and its ack cycle a.
    // Strobe at g+1, busy over g+1..a, ack and read data at a; next grant from a+1 onward.
    logic [31:0] shadow [MW];
    int          g_cyc = -100, a_cyc = -100, m_starve = 0;
    logic        m_owner = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_din = '0, m_irdata = '0, m_drdata = '0, m_rd_val = '0;
    logic [3:0]  m_sel = 4'h0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                g_cyc = -100; a_cyc = -100; m_starve = 0; m_owner = 1'b0; m_we = 1'b0;
                m_addr = '0; m_din = '0; m_sel = 4'h0; m_irdata = '0; m_drdata = '0;
            end else begin
                if (cyc == a_cyc && !m_we) begin
                    if (m_owner) m_drdata = m_rd_val;
                    else         m_irdata = m_rd_val;
                end
                if (cyc - 1 > a_cyc) begin : arbitrate
                    logic gd, gi;
                    gd = d_req && !(i_req && m_starve == SMAX);
                    gi = i_req && !gd;
                    if (gd) begin
                        m_owner = 1'b1; m_we = d_we; m_addr = d_addr; m_din = d_wdata;
                        m_sel = d_we ? d_sel : 4'hf;
                    end else if (gi) begin
                        m_owner = 1'b0; m_we = 1'b0; m_addr = i_addr; m_din = '0; m_sel = 4'hf;
                    end
                    if (gd || gi) begin
                        g_cyc = cyc - 1;
                        a_cyc = g_cyc + 2 + (m_we ? 0 : LAT);
                        if (m_we) shadow[m_addr[4:0]] = merge(shadow[m_addr[4:0]], m_din, m_sel);
                        else      m_rd_val = shadow[m_addr[4:0]];
                    end
                    if (!i_req || gi)                 m_starve = 0;
                    else if (gd && m_starve < SMAX)   m_starve++;
                end
            end
        end
    end

    // Every-cycle comparison of the main instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("ram_en",   {31'h0, ram_en}, {31'h0, cyc == g_cyc + 1});
                chk("busy",     {31'h0, busy},   {31'h0, (cyc > g_cyc) && (cyc <= a_cyc)});
                chk("i_ack",    {31'h0, i_ack},  {31'h0, (cyc == a_cyc) && !m_owner});
                chk("d_ack",    {31'h0, d_ack},  {31'h0, (cyc == a_cyc) && m_owner});
                chk("i_rdata",  i_rdata,  m_irdata);
                chk("d_rdata",  d_rdata,  m_drdata);
                chk("ram_we",   {31'h0, ram_we}, {31'h0, m_we});
                chk("ram_addr", ram_addr, m_addr);
                chk("ram_din",  ram_din,  m_din);
                chk("ram_sel",  {28'h0, ram_sel}, {28'h0, m_sel});
            end
        end
    end

    // ---------------- RAM models ----------------
    logic [31:0] ram_mem [MW];
    logic [31:0] pipe1 [LAT];
    logic [31:0] pipe3 [LAT3];

    // Main RAM: read data appears RAM_LAT cycles after the strobe cycle, filler otherwise.
    initial begin
        for (int k = 0; k < LAT; k++) pipe1[k] = '0;
        ram_dout = '0;
        forever begin
            @(negedge clk);
            ram_dout = pipe1[LAT-1];
            for (int k = LAT - 1; k > 0; k--) pipe1[k] = pipe1[k-1];
            pipe1[0] = (ram_en && !ram_we) ? ram_mem[ram_addr[4:0]] : (32'hBAD0_0000 ^ 32'(cyc));
            if (ram_en && ram_we) ram_mem[ram_addr[4:0]] = merge(ram_mem[ram_addr[4:0]], ram_din, ram_sel);
        end
    end

    // RAM for the RAM_LAT=3 instance: read-only, contents are a function of address.
    initial begin
        for (int k = 0; k < LAT3; k++) pipe3[k] = '0;
        ram_dout3 = '0;
        forever begin
            @(negedge clk);
            ram_dout3 = pipe3[LAT3-1];
            for (int k = LAT3 - 1; k > 0; k--) pipe3[k] = pipe3[k-1];
            pipe3[0] = (ram_en3 && !ram_we3) ? f3(ram_addr3) : (32'hBAD3_0000 ^ 32'(cyc));
        end
    end

    // Access on the RAM_LAT=3 instance; records the cycle offset at which its ack appears.
    task automatic acc3(input string name, input logic is_d, input logic we,
                        input logic [31:0] addr, input int ack_at);
        int seen;
        seen = -1;
        if (is_d) begin
            d_req3 = 1'b1; d_we3 = we; d_addr3 = addr; d_wdata3 = 32'h1234_5678; d_sel3 = 4'hf;
        end else begin
            i_req3 = 1'b1; i_addr3 = addr;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if ((is_d ? d_ack3 : i_ack3) && seen < 0) begin
                seen = k; d_req3 = 1'b0; i_req3 = 1'b0;
            end
        end
        chk(name, 32'(seen), 32'(ack_at));
    endtask

    // ---------------- stimulus ----------------
    logic        i_off, d_off;
    logic        gseq [10];
    int          ng, c0, nack, nbusy;

    initial begin
        rst_n = 1'b0; rst_n3 = 1'b0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_sel = 4'h0;
        i_req3 = 1'b0; i_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = '0; d_wdata3 = '0; d_sel3 = 4'h0;
        for (int k = 0; k < MW; k++) begin
            ram_mem[k] = $urandom;
            shadow[k]  = ram_mem[k];
        end
        ram_mem[16] = 32'hDEAD_BEEF; shadow[16] = 32'hDEAD_BEEF;
        ram_mem[5]  = 32'h5555_AAAA; shadow[5]  = 32'h5555_AAAA;

        repeat (3) @(negedge clk);
        chk("reset i_rdata", i_rdata, 32'h0);
        chk("reset ram_sel", {28'h0, ram_sel}, 32'h0);
        chk("reset busy",    {31'h0, busy},    32'h0);
        rst_n = 1'b1; rst_n3 = 1'b1;
        model_on = 1'b1;
        repeat (3) @(negedge clk);

        // Lone fetch: strobe at +1, ack with data at +3.
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        chk("lone_i ram_en",  {31'h0, ram_en}, 32'h1);
        chk("lone_i ram_we",  {31'h0, ram_we}, 32'h0);
        chk("lone_i ram_sel", {28'h0, ram_sel}, 32'hf);
        @(negedge clk);
        chk("lone_i early ack", {31'h0, i_ack}, 32'h0);
        @(negedge clk);
        chk("lone_i ack",   {31'h0, i_ack}, 32'h1);
        chk("lone_i rdata", i_rdata, 32'hDEAD_BEEF);
        i_req = 1'b0;
        repeat (2) @(negedge clk);

        // Single-byte store: ack at +2, never an I ack.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h00AB_0000; d_sel = 4'b0100;
        @(negedge clk);
        chk("store ram_we",  {31'h0, ram_we}, 32'h1);
        chk("store ram_sel", {28'h0, ram_sel}, 32'h4);
        chk("store ram_din", ram_din, 32'h00AB_0000);
        @(negedge clk);
        chk("store d_ack", {31'h0, d_ack}, 32'h1);
        chk("store i_ack", {31'h0, i_ack}, 32'h0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        // Starvation: both held; expect D x4, I, D x4, I.
        i_req = 1'b1; i_addr = 32'h1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2; d_wdata = 32'h0102_0304; d_sel = 4'hf;
        ng = 0;
        for (int n = 0; n < 80 && ng < 10; n++) begin
            @(negedge clk);
            if (ram_en) begin
                gseq[ng] = (ram_addr == 32'h2);
                ng++;
            end
        end
        chk("starve grant count", 32'(ng), 32'd10);
        for (int k = 0; k < 10; k++) chk("starve grant owner", {31'h0, gseq[k]}, {31'h0, (k % 5) != 4});
        i_req = 1'b0; d_req = 1'b0;
        repeat (6) @(negedge clk);

        // Withdraw right after grant and disturb the address: still exactly one ack.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5;
        @(negedge clk);
        chk("withdraw ram_en", {31'h0, ram_en}, 32'h1);
        d_req = 1'b0; d_addr = 32'h1F;
        @(negedge clk);
        chk("withdraw ram_addr held", ram_addr, 32'h5);
        nack = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) chk("withdraw d_rdata", d_rdata, 32'h5555_AAAA);
            if (d_ack) nack++;
            @(negedge clk);
        end
        chk("withdraw ack count", 32'(nack), 32'd1);

        // Random traffic against the model.
        i_off = 1'b0; d_off = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            if (i_ack) begin
                i_req = 1'b0; i_off = 1'b0;
                if ($urandom_range(0, 1) == 0) begin i_req = 1'b1; i_addr = 32'($urandom_range(0, 31)); end
            end else if (!i_req && !i_off) begin
                if ($urandom_range(0, 3) == 0) begin i_req = 1'b1; i_addr = 32'($urandom_range(0, 31)); end
            end else if (i_req && !m_owner && cyc > g_cyc && cyc < a_cyc && $urandom_range(0, 9) == 0) begin
                i_req = 1'b0; i_off = 1'b1; i_addr = 32'($urandom_range(0, 31));
            end
            if (d_ack) begin
                d_req = 1'b0; d_off = 1'b0;
            end else if (d_req && m_owner && cyc > g_cyc && cyc < a_cyc) begin
                d_addr = 32'($urandom_range(0, 31)); d_wdata = $urandom;
                if ($urandom_range(0, 9) == 0) begin d_req = 1'b0; d_off = 1'b1; end
            end
            if (!d_req && !d_off && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = 32'($urandom_range(0, 31));
                d_wdata = $urandom;
                d_sel = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (10) @(negedge clk);

        // RAM_LAT=3 instance: read acks at +5, store at +2, d_rdata holds across other accesses.
        acc3("lat3 d load ack", 1'b1, 1'b0, 32'h7, 5);
        chk("lat3 d_rdata", d_rdata3, f3(32'h7));
        acc3("lat3 i read ack", 1'b0, 1'b0, 32'h9, 5);
        chk("lat3 i_rdata", i_rdata3, f3(32'h9));
        chk("lat3 d_rdata hold after i", d_rdata3, f3(32'h7));
        acc3("lat3 store ack", 1'b1, 1'b1, 32'h3, 2);
        chk("lat3 d_rdata hold after store", d_rdata3, f3(32'h7));
        acc3("lat3 second load ack", 1'b1, 1'b0, 32'hA, 5);
        chk("lat3 d_rdata new", d_rdata3, f3(32'hA));

        // Reset in the middle of a read wait.
        d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'hB;
        repeat (3) @(negedge clk);
        chk("rst3 busy before", {31'h0, busy3}, 32'h1);
        rst_n3 = 1'b0;
        #1;
        chk("rst3 busy",     {31'h0, busy3},   32'h0);
        chk("rst3 ram_en",   {31'h0, ram_en3}, 32'h0);
        chk("rst3 ram_addr", ram_addr3, 32'h0);
        chk("rst3 ram_sel",  {28'h0, ram_sel3}, 32'h0);
        chk("rst3 d_rdata",  d_rdata3, 32'h0);
        chk("rst3 i_rdata",  i_rdata3, 32'h0);
        d_req3 = 1'b0;
        @(negedge clk);
        rst_n3 = 1'b1;
        nack = 0; nbusy = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_ack3 || i_ack3) nack++;
            if (busy3) nbusy++;
        end
        chk("rst3 acks after release", 32'(nack), 32'd0);
        chk("rst3 busy after release", 32'(nbusy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
